// File: rtl/clm_aes_host_ctrl.sv
// Host-side initiator for the CLM AES core: request/response handshakes, core start, watchdog recovery.
// Optional build macro CLM_HOST_INTERNAL_RNG_EN selects an internal xorshift32 mask generator instead of ext_random.
module clm_aes_host_ctrl #(
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] SEED           = 32'h0000_0001,
    parameter int          RED_POLY_W     = 9,
    parameter int          P_DET_W        = 4,
    parameter int          RV_W           = 23 * RED_POLY_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [127:0]        req_plaintext,
    input  logic [127:0]        req_key,
    input  logic [P_DET_W-1:0]  req_p_det,
    output logic                core_rst,
    output logic                core_drdy_i,
    output logic [127:0]        core_plaintext,
    output logic [127:0]        core_key,
    output logic [P_DET_W-1:0]  core_p_det,
    output logic [RV_W-1:0]     core_random_vect,
    input  logic                core_drdy_o,
    input  logic [127:0]        core_ciphertext,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [127:0]        resp_ciphertext,
    output logic                resp_timeout,
    input  logic [RV_W-1:0]     ext_random
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RECOVER,
        S_RESP
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   wd_cnt, wd_cnt_nxt;
    logic            wd_expire;
    logic            rec_second;
    logic            accept, capture, time_out;

    // Saturating watchdog; the WAIT cycle whose increment reaches the limit is the expiry cycle.
    assign wd_cnt_nxt = (wd_cnt == CW'(TIMEOUT_CYCLES)) ? wd_cnt : wd_cnt + CW'(1);
    assign wd_expire  = (wd_cnt_nxt == CW'(TIMEOUT_CYCLES));
    assign req_ready  = (state == S_IDLE);

    always_comb begin
        state_n  = state;
        accept   = 1'b0;
        capture  = 1'b0;
        time_out = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    state_n = S_START;
                    accept  = 1'b1;
                end
            end
            S_START: state_n = S_WAIT;
            S_WAIT: begin
                if (core_drdy_o) begin
                    state_n = S_RESP;
                    capture = 1'b1;
                end else if (wd_expire) begin
                    state_n  = S_RECOVER;
                    time_out = 1'b1;
                end
            end
            S_RECOVER: begin
                if (rec_second) state_n = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up exactly with the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            wd_cnt          <= '0;
            rec_second      <= 1'b0;
            core_rst        <= 1'b1;
            core_drdy_i     <= 1'b0;
            core_plaintext  <= '0;
            core_key        <= '0;
            core_p_det      <= '0;
            resp_valid      <= 1'b0;
            resp_ciphertext <= '0;
            resp_timeout    <= 1'b0;
        end else begin
            state       <= state_n;
            core_rst    <= (state_n == S_RECOVER);
            core_drdy_i <= (state_n == S_START);
            resp_valid  <= (state_n == S_RESP);
            rec_second  <= (state == S_RECOVER) && !rec_second;
            if (accept) begin
                core_plaintext <= req_plaintext;
                core_key       <= req_key;
                core_p_det     <= req_p_det;
                wd_cnt         <= '0;
            end else if (state == S_WAIT) begin
                wd_cnt <= wd_cnt_nxt;
            end
            if (capture) begin
                resp_ciphertext <= core_ciphertext;
                resp_timeout    <= 1'b0;
            end else if (time_out) begin
                resp_ciphertext <= '0;
                resp_timeout    <= 1'b1;
            end
        end
    end

`ifdef CLM_HOST_INTERNAL_RNG_EN
    localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;

    function automatic logic [31:0] xorshift32(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    logic [31:0] xs_state;
    logic [31:0] xs_next;
    logic        unused_ext;

    assign xs_next    = xorshift32(xs_state);
    assign unused_ext = ^ext_random;

    // Each new word enters at the LSBs, so the whole mask bus refreshes every ceil(RV_W/32) cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xs_state         <= SEED_EFF;
            core_random_vect <= '0;
        end else begin
            xs_state         <= xs_next;
            core_random_vect <= {core_random_vect[RV_W-33:0], xs_next};
        end
    end
`else
    logic unused_seed;
    assign unused_seed = ^SEED;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) core_random_vect <= '0;
        else     core_random_vect <= ext_random;
    end
`endif

endmodule

// File: tb/tb_clm_aes_host_ctrl.sv
// Self-checking bench for clm_aes_host_ctrl with a stub core of programmable latency (0 = never answers).
module tb_clm_aes_host_ctrl;

    localparam int T   = 64;
    localparam int PW  = 4;
    localparam int RPW = 9;
    localparam int RVW = 23 * RPW;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic [127:0]   req_plaintext = '0;
    logic [127:0]   req_key = '0;
    logic [PW-1:0]  req_p_det = '0;
    logic           core_rst;
    logic           core_drdy_i;
    logic [127:0]   core_plaintext;
    logic [127:0]   core_key;
    logic [PW-1:0]  core_p_det;
    logic [RVW-1:0] core_random_vect;
    logic           core_drdy_o = 1'b0;
    logic [127:0]   core_ciphertext = '0;
    logic           resp_valid;
    logic           resp_ready = 1'b0;
    logic [127:0]   resp_ciphertext;
    logic           resp_timeout;
    logic [RVW-1:0] ext_random = '0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int core_delay = 0;
    int stub_cnt = 0;

    int drdy_pulses = 0, drdy_cyc = 0, rst_cycles = 0, rst_rise_cyc = 0;
    int resp_rises = 0, resp_rise_cyc = 0, op_change = 0;
    logic prev_core_rst = 1'b1, prev_resp_valid = 1'b0, prev_ready = 1'b1;
    logic [255+PW:0] prev_ops = '0;

    clm_aes_host_ctrl #(
        .TIMEOUT_CYCLES (T),
        .SEED           (32'h0),
        .RED_POLY_W     (RPW),
        .P_DET_W        (PW),
        .RV_W           (RVW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_plaintext    (req_plaintext),
        .req_key          (req_key),
        .req_p_det        (req_p_det),
        .core_rst         (core_rst),
        .core_drdy_i      (core_drdy_i),
        .core_plaintext   (core_plaintext),
        .core_key         (core_key),
        .core_p_det       (core_p_det),
        .core_random_vect (core_random_vect),
        .core_drdy_o      (core_drdy_o),
        .core_ciphertext  (core_ciphertext),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_ciphertext  (resp_ciphertext),
        .resp_timeout     (resp_timeout),
        .ext_random       (ext_random)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Core behaviour: FIPS-197 vector answered correctly, anything else by a fixed scramble.
    function automatic logic [127:0] core_fn(input logic [127:0] pt, input logic [127:0] key);
        if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
        return pt ^ {key[63:0], key[127:64]} ^ 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;
    endfunction

    function automatic logic [31:0] xs32(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [RVW-1:0] rand_rv();
        logic [RVW-1:0] v;
        v = '0;
        for (int i = 0; i < (RVW + 31) / 32; i++) v = {v[RVW-33:0], $urandom};
        return v;
    endfunction

    always @(posedge clk) begin
        core_drdy_o <= 1'b0;
        if (rst || core_rst) begin
            stub_cnt <= 0;
        end else if (core_drdy_i) begin
            if (core_delay == 1) begin
                core_drdy_o     <= 1'b1;
                core_ciphertext <= core_fn(core_plaintext, core_key);
            end
            stub_cnt <= (core_delay > 1) ? core_delay - 1 : 0;
        end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) begin
                core_drdy_o     <= 1'b1;
                core_ciphertext <= core_fn(core_plaintext, core_key);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (core_drdy_i) begin
                drdy_pulses <= drdy_pulses + 1;
                drdy_cyc    <= cyc;
            end
            if (core_rst) begin
                rst_cycles <= rst_cycles + 1;
                if (!prev_core_rst) rst_rise_cyc <= cyc;
            end
            if (resp_valid && !prev_resp_valid) begin
                resp_rises    <= resp_rises + 1;
                resp_rise_cyc <= cyc;
            end
            if (!prev_ready && !req_ready && ({core_plaintext, core_key, core_p_det} !== prev_ops))
                op_change <= op_change + 1;
        end
        prev_core_rst   <= core_rst;
        prev_resp_valid <= resp_valid;
        prev_ready      <= req_ready;
        prev_ops        <= {core_plaintext, core_key, core_p_det};
    end

    task automatic chk_v(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick_n();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk_i({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk_i({tag, "_core_rst"}, 32'(core_rst), 32'd1);
        chk_i({tag, "_drdy_i"}, 32'(core_drdy_i), 32'd0);
        chk_i({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk_i({tag, "_resp_timeout"}, 32'(resp_timeout), 32'd0);
        chk_v({tag, "_resp_ct"}, 256'(resp_ciphertext), 256'd0);
        chk_v({tag, "_hold"}, 256'({core_plaintext, core_key} ^ 256'(core_p_det)), 256'd0);
        chk_v({tag, "_rv"}, 256'(core_random_vect), 256'd0);
    endtask

    // One full transaction against the reference: latency d (1..T answers, else watchdog), bp stall cycles.
    task automatic do_req(input logic [127:0] pt, input logic [127:0] key, input logic [PW-1:0] pd,
                          input int d, input int bp, input bit keep);
        int n_drdy, n_rst, n_rise, n_op, w;
        bit ok;
        logic [127:0] exp_ct;
        ok     = (d >= 1 && d <= T);
        exp_ct = ok ? core_fn(pt, key) : 128'd0;
        n_drdy = drdy_pulses;
        n_rst  = rst_cycles;
        n_rise = resp_rises;
        n_op   = op_change;
        core_delay    = d;
        req_plaintext = pt;
        req_key       = key;
        req_p_det     = pd;
        req_valid     = 1'b1;
        w = 0;
        while (!req_ready && w < 200) begin tick_n(); w++; end
        chk_i("accept_wait", 32'(w < 200), 32'd1);
        @(posedge clk);
        #1;
        if (keep) begin
            req_plaintext = rand128();
            req_key       = rand128();
            req_p_det     = PW'($urandom);
        end else begin
            req_valid = 1'b0;
        end
        tick_n();
        chk_i("start_drdy_i", 32'(core_drdy_i), 32'd1);
        chk_i("start_req_ready", 32'(req_ready), 32'd0);
        chk_v("hold_plaintext", 256'(core_plaintext), 256'(pt));
        chk_v("hold_key", 256'(core_key), 256'(key));
        chk_v("hold_p_det", 256'(core_p_det), 256'(pd));
        w = 0;
        while (!resp_valid && w < 300) begin tick_n(); w++; end
        chk_i("resp_wait", 32'(w < 300), 32'd1);
        chk_i("resp_latency", 32'(resp_rise_cyc - drdy_cyc), ok ? 32'(d + 1) : 32'(T + 3));
        chk_v("resp_ct", 256'(resp_ciphertext), 256'(exp_ct));
        chk_i("resp_timeout", 32'(resp_timeout), 32'(!ok));
        chk_i("resp_req_ready", 32'(req_ready), 32'd0);
        if (!ok) chk_i("recover_start", 32'(rst_rise_cyc - drdy_cyc), 32'(T + 1));
        for (int i = 0; i < bp; i++) begin
            tick_n();
            chk_i("bp_valid", 32'(resp_valid), 32'd1);
            chk_v("bp_ct", 256'(resp_ciphertext), 256'(exp_ct));
            chk_i("bp_timeout", 32'(resp_timeout), 32'(!ok));
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        tick_n();
        chk_i("resp_drop", 32'(resp_valid), 32'd0);
        chk_i("idle_req_ready", 32'(req_ready), 32'd1);
        chk_i("drdy_i_pulses", 32'(drdy_pulses - n_drdy), 32'd1);
        chk_i("core_rst_cycles", 32'(rst_cycles - n_rst), ok ? 32'd0 : 32'd2);
        chk_i("resp_rises", 32'(resp_rises - n_rise), 32'd1);
        chk_i("hold_stable", 32'(op_change - n_op), 32'd0);
    endtask

    initial begin
        int n_rise;
`ifdef CLM_HOST_INTERNAL_RNG_EN
        logic [31:0] m, mprev;
`else
        logic [RVW-1:0] r_old, r_new;
`endif
        tick_n();
        tick_n();
        chk_reset_values("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick_n();
        chk_i("core_rst_until_edge", 32'(core_rst), 32'd1);
        tick_n();
        chk_i("core_rst_released", 32'(core_rst), 32'd0);
`ifdef CLM_HOST_INTERNAL_RNG_EN
        chk_v("rng_first_word", 256'(core_random_vect[31:0]), 256'(32'h0004_2021));
        m = 32'h0004_2021;
        for (int i = 0; i < 3; i++) begin
            mprev = m;
            m     = xs32(m);
            tick_n();
            chk_v("rng_word", 256'(core_random_vect[31:0]), 256'(m));
            chk_v("rng_shift", 256'(core_random_vect[63:32]), 256'(mprev));
        end
`else
        r_old = '0;
        for (int i = 0; i < 4; i++) begin
            r_new      = rand_rv();
            ext_random = r_new;
            #1;
            chk_v("rv_registered", 256'(core_random_vect), 256'(r_old));
            tick_n();
            chk_v("rv_delay1", 256'(core_random_vect), 256'(r_new));
            r_old = r_new;
        end
`endif
        do_req(FIPS_PT, FIPS_KEY, 4'h3, 12, 5, 1'b0);
        for (int i = 0; i < 3; i++)
            do_req(rand128(), rand128(), PW'($urandom), int'($urandom_range(1, 40)), int'($urandom_range(0, 3)), 1'b0);
        for (int i = 0; i < 3; i++)
            do_req(rand128(), rand128(), PW'($urandom), int'($urandom_range(1, 20)), 0, i < 2);
        do_req(rand128(), rand128(), PW'($urandom), T, 1, 1'b0);
        do_req(rand128(), rand128(), PW'($urandom), 0, 2, 1'b0);
        do_req(rand128(), rand128(), PW'($urandom), T + 1, 0, 1'b0);

        // Reset while the core is being waited on: request must vanish without a response.
        core_delay    = 0;
        n_rise        = resp_rises;
        req_plaintext = rand128();
        req_key       = rand128();
        req_valid     = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (10) tick_n();
        chk_i("wait_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk_reset_values("midrst");
        tick_n();
        tick_n();
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick_n();
        chk_i("midrst_core_rst_hold", 32'(core_rst), 32'd1);
        tick_n();
        chk_i("midrst_core_rst_rel", 32'(core_rst), 32'd0);
        chk_i("midrst_no_resp", 32'(resp_rises - n_rise), 32'd0);
        chk_i("midrst_resp_valid", 32'(resp_valid), 32'd0);
        do_req(rand128(), rand128(), PW'($urandom), int'($urandom_range(1, 30)), 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clm_aes_host_ctrl.md
# clm_aes_host_ctrl

Host-side initiator for the CLM AES encryption core. It accepts encryption requests over a valid/ready channel and drives the core's `clm_inouts_if` basic port: plaintext, key, `drdy_i`, `p_det` and the `random_vect` mask bus. It waits for the core's `drdy_o` pulse, captures the ciphertext and returns it over a second valid/ready channel. A watchdog resets a hung core and reports a timeout.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024: maximum cycles in WAIT before recovery; legal range 64..65535.
- SEED, 32'h0000_0001: xorshift32 reset seed; the value 0 is replaced by 1.
- RV_W, 23*$bits(red_poly_t): width of the flattened random vector.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high together with req_valid
- req_plaintext  in  128  plaintext block
- req_key  in  128  cipher key
- req_p_det  in  $bits(p_det_t)  modulus selector for this block
- core_rst  out  1  registered reset to the core; high while rst or in RECOVER
- core_drdy_i  out  1  start pulse to the core
- core_plaintext, core_key  out  128  held operands
- core_p_det  out  $bits(p_det_t)  held selector
- core_random_vect  out  RV_W  mask bits (red_poly_t [0:22])
- core_drdy_o  in  1  core done pulse
- core_ciphertext  in  128  core result
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed
- resp_ciphertext  out  128  result
- resp_timeout  out  1  response carries a timeout, not a ciphertext
- ext_random  in  RV_W  external mask source; used only when the RNG is compiled out

## Operation
- States: IDLE, START, WAIT, RECOVER, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch plaintext, key and p_det into the hold registers, clear the watchdog counter, go to START.
- START:
  - core_drdy_i=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - The counter increments each cycle.
  - If core_drdy_o=1: capture core_ciphertext into resp_ciphertext, set resp_timeout=0, go to RESP.
  - Else, when the counter reaches TIMEOUT_CYCLES: go to RECOVER.
  - If core_drdy_o arrives in the same cycle as expiry, core_drdy_o wins.
- RECOVER:
  - core_rst=1 for exactly 2 cycles.
  - resp_ciphertext is set to 0 and resp_timeout to 1; go to RESP.
- RESP:
  - resp_valid=1; resp_ciphertext and resp_timeout are held.
  - On resp_ready: go to IDLE.
  - A new request cannot be accepted in the same cycle as the response handshake (req_ready=0 outside IDLE).
- Hold registers (core_plaintext, core_key, core_p_det) change only on IDLE acceptance. They stay stable through START, WAIT and RECOVER, which is required because the core samples p_det in CALC_PARAMS and the operands in PREP_DATA.
- core_drdy_o outside WAIT is ignored.
- Watchdog counter width: $clog2(TIMEOUT_CYCLES+1). The counter saturates and never wraps.

## Timing
- Reset values:
  - State = IDLE, req_ready=1, core_rst=1 (released on the first clk edge after rst deasserts).
  - core_drdy_i=0, all hold registers 0.
  - resp_valid=0, resp_ciphertext=0, resp_timeout=0.
  - RNG state = SEED (or 1), core_random_vect=0.
- Request handshake at edge N: START during cycle N+1; core_drdy_i is high in cycle N+1 only.
- core_drdy_o sampled high at edge M: resp_valid is high from cycle M+1.
- Timeout: RECOVER is entered TIMEOUT_CYCLES+1 cycles after START. resp_valid rises 2 cycles later, with resp_timeout=1.
- rst asserted mid-operation: immediate return to reset values; an in-flight request is dropped with no response.
- All outputs are registered. There is no combinational path from input to output except req_ready, which is decoded from state.

## Configuration
- CLM_HOST_INTERNAL_RNG_EN defined:
  - A xorshift32 generator (shifts 13, 17, 5) advances every cycle.
  - core_random_vect is a shift register: each cycle it shifts left by 32 and inserts the new xorshift word at the LSBs, so every bit is refreshed within ceil(RV_W/32) cycles.
  - ext_random is ignored.
- CLM_HOST_INTERNAL_RNG_EN undefined:
  - No generator.
  - core_random_vect is ext_random registered each cycle (reset value 0).
  - The SEED parameter is unused.

## Test plan
- FIPS-197 block with correct core: key 000102…0f, plaintext 00112233…eeff, p_det fixed, with back-pressure on resp_ready (resp_ready=0 for 5 cycles) -> one core_drdy_i pulse; resp_ciphertext=69c4e0d86a7b0430d8cdb78070b4c55a, resp_timeout=0, held stable while resp_ready=0, transfers when it goes high.
- Back-to-back requests with req_valid held: each accepted only in IDLE -> exactly one core_drdy_i pulse per block; operands unchanged during WAIT.
- Stub core never raising drdy_o, TIMEOUT_CYCLES=64 -> core_rst high for exactly 2 cycles, 65 cycles after START; then resp_valid=1, resp_timeout=1, resp_ciphertext=0.
- core_drdy_o raised in the expiry cycle -> ciphertext captured, resp_timeout=0, core_rst not pulsed.
- rst asserted in WAIT -> all outputs return to reset values; no resp_valid; the next request completes normally.
- RNG: SEED=0 with the macro defined -> first inserted word is xorshift32(1)=0x00042021; without the macro, core_random_vect equals ext_random delayed by 1 cycle.
